// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: a one-hot T1..T6 ring counter decoded with the IR opcode into bus/load strobes.
// Define SAP_CTRL_FAST_CYCLE_EN to end OUT/NOP after T4 and LDA after T5 instead of always running six states.
module sap_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [3:0] ir_opcode,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       out_load,
    output logic [5:0] t_state,
    output logic       halted
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

`ifdef SAP_CTRL_FAST_CYCLE_EN
    localparam logic FAST_CYCLE = 1'b1;
`else
    localparam logic FAST_CYCLE = 1'b0;
`endif

    logic [5:0] state_q;
    logic [5:0] state_d;
    logic       halted_q;
    logic       halted_d;
    logic       uses_t5_s;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Instructions that need the T5 memory step (only relevant in the short-cycle build)
    always_comb begin
        uses_t5_s = (ir_opcode == OP_LDA) || (ir_opcode == OP_ADD) || (ir_opcode == OP_SUB);
    end

    // Next-state ring advance; HLT freezes the ring at T4 until reset
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (halted_q || !ena) begin
            state_d = state_q;
        end else begin
            case (state_q)
                T1: state_d = T2;
                T2: state_d = T3;
                T3: state_d = T4;
                T4: begin
                    if (ir_opcode == OP_HLT) begin
                        state_d  = T4;
                        halted_d = 1'b1;
                    end else if (FAST_CYCLE && !uses_t5_s) begin
                        state_d = T1;
                    end else begin
                        state_d = T5;
                    end
                end
                T5: begin
                    if (FAST_CYCLE && (ir_opcode == OP_LDA)) begin
                        state_d = T1;
                    end else begin
                        state_d = T6;
                    end
                end
                T6:      state_d = T1;
                default: state_d = T1;
            endcase
        end
    end

    // Microcode decode: drives follow state/opcode, loads and pc_inc are gated by ena
    always_comb begin
        pc_inc   = 1'b0;
        pc_out   = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_sub  = 1'b0;
        alu_out  = 1'b0;
        out_load = 1'b0;
        // Halted collapses to an all-zero decode
        case (halted_q ? 6'b000000 : state_q)
            T1: begin
                pc_out   = 1'b1;
                mar_load = ena;
            end
            T2: pc_inc = ena;
            T3: begin
                ram_out = 1'b1;
                ir_load = ena;
            end
            T4: begin
                case (ir_opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ir_out   = 1'b1;
                        mar_load = ena;
                    end
                    OP_OUT: begin
                        a_out    = 1'b1;
                        out_load = ena;
                    end
                    default: ir_out = 1'b0;
                endcase
            end
            T5: begin
                case (ir_opcode)
                    OP_LDA: begin
                        ram_out = 1'b1;
                        a_load  = ena;
                    end
                    OP_ADD, OP_SUB: begin
                        ram_out = 1'b1;
                        b_load  = ena;
                        alu_sub = (ir_opcode == OP_SUB);
                    end
                    default: ram_out = 1'b0;
                endcase
            end
            T6: begin
                case (ir_opcode)
                    OP_ADD, OP_SUB: begin
                        alu_out = 1'b1;
                        a_load  = ena;
                        alu_sub = (ir_opcode == OP_SUB);
                    end
                    default: alu_out = 1'b0;
                endcase
            end
            default: pc_out = 1'b0;
        endcase
    end

    assign t_state = state_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_sap_controller.sv
// Directed and randomized checks for sap_controller; honours SAP_CTRL_FAST_CYCLE_EN for cycle-length expectations.
module tb_sap_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic [3:0] ir_opcode;
    logic       pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_sub, alu_out, out_load;
    logic [5:0] t_state;
    logic       halted;
    logic [11:0] ctrl_s;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SAP_CTRL_FAST_CYCLE_EN
    localparam bit FAST_B = 1'b1;
    localparam int LEN_OUT = 4;
    localparam int LEN_LDA = 5;
`else
    localparam bit FAST_B = 1'b0;
    localparam int LEN_OUT = 6;
    localparam int LEN_LDA = 6;
`endif

    sap_controller dut (
        .clk(clk), .reset(reset), .ena(ena), .ir_opcode(ir_opcode),
        .pc_inc(pc_inc), .pc_out(pc_out), .mar_load(mar_load), .ram_out(ram_out),
        .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
        .b_load(b_load), .alu_sub(alu_sub), .alu_out(alu_out), .out_load(out_load),
        .t_state(t_state), .halted(halted)
    );

    always #5 clk = ~clk;

    // bit order: pc_inc pc_out mar_load ram_out ir_load ir_out a_load a_out b_load alu_sub alu_out out_load
    assign ctrl_s = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
                     a_load, a_out, b_load, alu_sub, alu_out, out_load};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starting at T1, count qualified edges until the ring returns to T1
    task automatic run_len(input logic [3:0] op, input int exp_len, input string tag);
        int n;
        n = 0;
        ir_opcode = op;
        ena = 1'b1;
        do begin
            tick();
            n++;
        end while (t_state !== 6'h01 && n < 12);
        check(tag, 32'(n), 32'(exp_len));
    endtask

    int  idx;
    bit  mh;
    logic [3:0] op_r;

    initial begin
        reset = 1'b1; ena = 1'b0; ir_opcode = 4'h0;
        tick(); tick();
        check("rst_t", 32'(t_state), 32'h01);
        check("rst_halt", 32'(halted), 32'h0);
        check("rst_ctrl_ena0", 32'(ctrl_s), 32'h400);
        ena = 1'b1; #1;
        check("rst_ctrl_ena1", 32'(ctrl_s), 32'h600);
        tick();
        check("rst_wins_t", 32'(t_state), 32'h01);

        // Fetch, with opcode wiggling during T1..T3, then SUB execute
        reset = 1'b0; ir_opcode = 4'hE; #1;
        check("t1_ctrl", 32'(ctrl_s), 32'h600);
        tick(); check("t2_state", 32'(t_state), 32'h02);
        ir_opcode = 4'hF; #1;
        check("t2_ctrl", 32'(ctrl_s), 32'h800);
        tick(); check("t3_state", 32'(t_state), 32'h04);
        ir_opcode = 4'h0; #1;
        check("t3_ctrl", 32'(ctrl_s), 32'h180);
        tick(); check("t4_state", 32'(t_state), 32'h08);
        ir_opcode = 4'h2; #1;
        check("sub_t4", 32'(ctrl_s), 32'h240);
        tick(); check("sub_t5_state", 32'(t_state), 32'h10);
        check("sub_t5", 32'(ctrl_s), 32'h10C);
        tick(); check("sub_t6_state", 32'(t_state), 32'h20);
        check("sub_t6", 32'(ctrl_s), 32'h026);
        tick(); check("sub_wrap", 32'(t_state), 32'h01);

        // ADD stalled in T5
        ir_opcode = 4'h1;
        repeat (4) tick();
        check("add_t5_state", 32'(t_state), 32'h10);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("add_hold_t", 32'(t_state), 32'h10);
            check("add_hold_ctrl", 32'(ctrl_s), 32'h100);
            tick();
        end
        ena = 1'b1; #1;
        check("add_t5_ena", 32'(ctrl_s), 32'h108);
        tick();
        check("add_t6", 32'(ctrl_s), 32'h022);
        tick();
        check("add_wrap", 32'(t_state), 32'h01);

        // LDA decode and instruction lengths
        ir_opcode = 4'h0;
        repeat (3) tick();
        check("lda_t4", 32'(ctrl_s), 32'h240);
        tick();
        check("lda_t5", 32'(ctrl_s), 32'h120);
        reset = 1'b1; tick(); reset = 1'b0;
        ir_opcode = 4'hE;
        repeat (3) tick();
        check("out_t4", 32'(ctrl_s), 32'h011);
        reset = 1'b1; tick(); reset = 1'b0;
        run_len(4'hE, LEN_OUT, "len_out");
        run_len(4'h0, LEN_LDA, "len_lda");
        run_len(4'h1, 6, "len_add");
        run_len(4'h7, LEN_OUT, "len_nop");
        run_len(4'h2, 6, "len_sub");

        // Halt
        ir_opcode = 4'hF;
        repeat (3) tick();
        check("hlt_t4_state", 32'(t_state), 32'h08);
        check("hlt_t4_ctrl", 32'(ctrl_s), 32'h000);
        tick();
        check("hlt_flag", 32'(halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            ir_opcode = 4'(i);
            #1;
            check("hlt_ctrl", 32'(ctrl_s), 32'h000);
            check("hlt_t", 32'(t_state), 32'h08);
            tick();
        end
        reset = 1'b1; tick(); reset = 1'b0; #1;
        check("hlt_rst_t", 32'(t_state), 32'h01);
        check("hlt_rst_flag", 32'(halted), 32'h0);

        // Random run against an index-based reference model
        reset = 1'b1; tick();
        idx = 0; mh = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            reset     = ($urandom_range(0, 63) == 0);
            ena       = 1'($urandom_range(0, 1));
            ir_opcode = 4'($urandom_range(0, 15));
            #1;
            check("onehot", 32'($countones(t_state)), 32'h1);
            check("drv_max1", 32'($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1), 32'h1);
            if (mh) check("rnd_halt_ctrl", 32'(ctrl_s), 32'h0);
            if (!ena) check("rnd_ena0_loads", 32'(ctrl_s & 12'hAA9), 32'h0);
            op_r = ir_opcode;
            @(posedge clk);
            if (reset) begin
                idx = 0; mh = 1'b0;
            end else if (!mh && ena) begin
                if (idx == 3 && op_r == 4'hF) mh = 1'b1;
                else if (idx == 5 ||
                         (FAST_B && ((idx == 3 && !(op_r inside {4'h0, 4'h1, 4'h2})) ||
                                     (idx == 4 && op_r == 4'h0)))) idx = 0;
                else idx++;
            end
            #1;
            check("rnd_t", 32'(t_state), 32'(1 << idx));
            check("rnd_halt", 32'(halted), 32'(mh));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
